// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST checker: FSM state encodings, gate
// selector codes and the parity helper used by the reference model.
package gate_bist_pkg;

    localparam int MAX_IN_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = ST_IDLE,
        S_SETTLE = ST_SETTLE,
        S_SAMPLE = ST_SAMPLE,
        S_DONE   = ST_DONE
    } state_e;

    localparam logic [1:0] GSEL_NOT = 2'b00;
    localparam logic [1:0] GSEL_AND = 2'b01;
    localparam logic [1:0] GSEL_OR  = 2'b10;
    localparam logic [1:0] GSEL_XOR = 2'b11;

    // Odd parity of a zero-extended vector; padding zeros do not change it.
    function automatic logic parity_of(input logic [MAX_IN_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/gate_bist_ref.sv
// Combinational golden model of the gates under test: maps (gate_sel, stim)
// to the expected gate output. NOT looks at stim[0] only.
module gate_ref_model #(
    parameter int IN_W = 2
) (
    input  logic [1:0]      gate_sel,
    input  logic [IN_W-1:0] stim,
    output logic            exp
);
    import gate_bist_pkg::*;

    logic [MAX_IN_W-1:0] stim_ext_s;

    // Select the reference function for the current gate type.
    always_comb begin
        stim_ext_s             = {MAX_IN_W{1'b0}};
        stim_ext_s[IN_W-1:0]   = stim;
        case (gate_sel)
            GSEL_NOT: exp = ~stim[0];
            GSEL_AND: exp = &stim;
            GSEL_OR:  exp = |stim;
            GSEL_XOR: exp = parity_of(stim_ext_s);
            default:  exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_bist_checker.sv
// Exhaustive stimulus/response checker: sweeps every input vector of a gate
// under test, compares its output against gate_ref_model and reports results.
module gate_bist_checker #(
    parameter int IN_W   = 2,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       gate_sel,
    output logic [IN_W-1:0]  stim,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [IN_W-1:0]  first_fail
);
    import gate_bist_pkg::*;

    localparam int               SC_W        = $clog2(SETTLE + 1);
    localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE - 1);
    localparam logic [IN_W-1:0]  STIM_LAST   = {IN_W{1'b1}};
    localparam logic [CNT_W-1:0] ERR_MAX     = {CNT_W{1'b1}};

    state_e             state_r, state_nxt_s;
    logic [SC_W-1:0]    cnt_r, cnt_nxt_s;
    logic [IN_W-1:0]    stim_r, stim_nxt_s;
    logic [IN_W-1:0]    first_fail_r, first_fail_nxt_s;
    logic [CNT_W-1:0]   err_r, err_nxt_s;
    logic               busy_r, busy_nxt_s;
    logic               done_r, done_nxt_s;
    logic               pass_r, pass_nxt_s;
    logic               exp_s;
    logic               mismatch_s;

    gate_ref_model #(.IN_W(IN_W)) u_ref (
        .gate_sel (gate_sel),
        .stim     (stim_r),
        .exp      (exp_s)
    );

    assign mismatch_s = (y != exp_s);

    assign stim       = stim_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign pass       = pass_r;
    assign err_count  = err_r;
    assign first_fail = first_fail_r;

    // Next-state and next-output logic; abort overrides every state.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        stim_nxt_s       = stim_r;
        first_fail_nxt_s = first_fail_r;
        err_nxt_s        = err_r;
        busy_nxt_s       = busy_r;
        done_nxt_s       = done_r;
        pass_nxt_s       = pass_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
            cnt_nxt_s   = {SC_W{1'b0}};
            stim_nxt_s  = {IN_W{1'b0}};
            busy_nxt_s  = 1'b0;
            done_nxt_s  = 1'b0;
            pass_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_nxt_s      = S_SETTLE;
                        cnt_nxt_s        = {SC_W{1'b0}};
                        stim_nxt_s       = {IN_W{1'b0}};
                        err_nxt_s        = {CNT_W{1'b0}};
                        first_fail_nxt_s = {IN_W{1'b0}};
                        busy_nxt_s       = 1'b1;
                        done_nxt_s       = 1'b0;
                        pass_nxt_s       = 1'b0;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                S_SETTLE: begin
                    cnt_nxt_s = cnt_r + SC_W'(1'b1);
                    if (cnt_r == SETTLE_LAST) begin
                        state_nxt_s = S_SAMPLE;
                    end else begin
                        state_nxt_s = S_SETTLE;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch_s) begin
                        if (err_r != ERR_MAX) begin
                            err_nxt_s = err_r + CNT_W'(1'b1);
                        end else begin
                            err_nxt_s = err_r;
                        end
                        if (err_r == {CNT_W{1'b0}}) begin
                            first_fail_nxt_s = stim_r;
                        end else begin
                            first_fail_nxt_s = first_fail_r;
                        end
                    end else begin
                        err_nxt_s = err_r;
                    end
                    if (stim_r == STIM_LAST) begin
                        state_nxt_s = S_DONE;
                        busy_nxt_s  = 1'b0;
                        done_nxt_s  = 1'b1;
                        pass_nxt_s  = (err_r == {CNT_W{1'b0}}) && !mismatch_s;
                    end else begin
                        state_nxt_s = S_SETTLE;
                        stim_nxt_s  = stim_r + IN_W'(1'b1);
                        cnt_nxt_s   = {SC_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt_s = S_IDLE;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= S_IDLE;
            cnt_r        <= {SC_W{1'b0}};
            stim_r       <= {IN_W{1'b0}};
            first_fail_r <= {IN_W{1'b0}};
            err_r        <= {CNT_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            stim_r       <= stim_nxt_s;
            first_fail_r <= first_fail_nxt_s;
            err_r        <= err_nxt_s;
            busy_r       <= busy_nxt_s;
            done_r       <= done_nxt_s;
            pass_r       <= pass_nxt_s;
        end
    end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker: three configurations driven by truth-table GUTs,
// checked against a sweep-level model of error count, first failure and latency.
module tb_gate_bist_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Instance a: defaults, combinational GUT
    logic       start_a = 1'b0, abort_a = 1'b0;
    logic [1:0] gsel_a = 2'd0;
    logic [1:0] stim_a, ff_a;
    logic       y_a, busy_a, done_a, pass_a;
    logic [7:0] err_a;
    logic [7:0] tt_a = 8'd0;
    // Instance b: IN_W=3, SETTLE=4, CNT_W=2, GUT registered by one cycle
    logic       start_b = 1'b0;
    logic [1:0] gsel_b = 2'd0;
    logic [2:0] stim_b, ff_b;
    logic       y_b = 1'b0, busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [7:0] tt_b = 8'd0;
    // Instance c: SETTLE=1, GUT registered by one cycle
    logic       start_c = 1'b0;
    logic [1:0] gsel_c = 2'd0;
    logic [1:0] stim_c, ff_c;
    logic       y_c = 1'b0, busy_c, done_c, pass_c;
    logic [7:0] err_c;
    logic [7:0] tt_c = 8'd0;

    assign y_a = tt_a[stim_a];
    always @(posedge clk) begin
        y_b <= tt_b[stim_b];
        y_c <= tt_c[stim_c];
    end

    gate_bist_checker #(.IN_W(2), .SETTLE(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .gate_sel(gsel_a),
        .stim(stim_a), .y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .first_fail(ff_a));
    gate_bist_checker #(.IN_W(3), .SETTLE(4), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(1'b0), .gate_sel(gsel_b),
        .stim(stim_b), .y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .first_fail(ff_b));
    gate_bist_checker #(.IN_W(2), .SETTLE(1), .CNT_W(8)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .abort(1'b0), .gate_sel(gsel_c),
        .stim(stim_c), .y(y_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .first_fail(ff_c));

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Gate definitions from their truth, not from any hardware structure.
    function automatic bit ref_fn(input int sel, input int v, input int w);
        case (sel)
            0:       return (v % 2) == 0;
            1:       return v == ((1 << w) - 1);
            2:       return v != 0;
            default: return ($countones(v) % 2) == 1;
        endcase
    endfunction

    function automatic int in_w_of(input int w);
        return (w == 1) ? 3 : 2;
    endfunction
    function automatic int settle_of(input int w);
        case (w) 0: return 2; 1: return 4; default: return 1; endcase
    endfunction
    function automatic int cnt_w_of(input int w);
        return (w == 1) ? 2 : 8;
    endfunction

    function automatic logic [7:0] stim_of(input int w);
        case (w) 0: return {6'd0, stim_a}; 1: return {5'd0, stim_b}; default: return {6'd0, stim_c}; endcase
    endfunction
    function automatic logic [7:0] ff_of(input int w);
        case (w) 0: return {6'd0, ff_a}; 1: return {5'd0, ff_b}; default: return {6'd0, ff_c}; endcase
    endfunction
    function automatic logic [7:0] err_of(input int w);
        case (w) 0: return err_a; 1: return {6'd0, err_b}; default: return err_c; endcase
    endfunction
    function automatic logic done_of(input int w);
        case (w) 0: return done_a; 1: return done_b; default: return done_c; endcase
    endfunction
    function automatic logic busy_of(input int w);
        case (w) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
    endfunction
    function automatic logic pass_of(input int w);
        case (w) 0: return pass_a; 1: return pass_b; default: return pass_c; endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w) 0: start_a = v; 1: start_b = v; default: start_c = v; endcase
    endtask
    task automatic set_cfg(input int w, input logic [1:0] sel, input logic [7:0] tt);
        case (w)
            0: begin gsel_a = sel; tt_a = tt; end
            1: begin gsel_b = sel; tt_b = tt; end
            default: begin gsel_c = sel; tt_c = tt; end
        endcase
    endtask

    // One full sweep on instance w; mid_start >= 0 pulses start while busy.
    task automatic run_sweep(input int w, input int sel, input logic [7:0] tt,
                             input int mid_start, input string tag);
        int  n, lat_exp, nmis, first, max_err, err_exp, cycles, nextv;
        bit  seq_ok;
        logic [7:0] last;
        n       = 1 << in_w_of(w);
        lat_exp = n * (settle_of(w) + 1);
        nmis    = 0;
        first   = 0;
        for (int v = 0; v < n; v++) begin
            if (tt[v] != ref_fn(sel, v, in_w_of(w))) begin
                if (nmis == 0) first = v;
                nmis++;
            end
        end
        max_err = (1 << cnt_w_of(w)) - 1;
        err_exp = (nmis > max_err) ? max_err : nmis;

        @(negedge clk);
        set_cfg(w, sel[1:0], tt);
        set_start(w, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(w, 1'b0);
        check_val({tag, "_busy"}, busy_of(w), 1);
        seq_ok = (stim_of(w) == 8'd0);
        last   = stim_of(w);
        nextv  = 1;
        cycles = 0;
        while (!done_of(w) && cycles < lat_exp + 20) begin
            set_start(w, cycles == mid_start);
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (stim_of(w) != last) begin
                if (int'(stim_of(w)) != nextv) seq_ok = 1'b0;
                nextv++;
                last = stim_of(w);
            end
        end
        set_start(w, 1'b0);
        check_val({tag, "_lat"}, cycles, lat_exp);
        check_val({tag, "_done"}, done_of(w), 1);
        check_val({tag, "_idle"}, busy_of(w), 0);
        check_val({tag, "_seq"}, (seq_ok && nextv == n) ? 1 : 0, 1);
        check_val({tag, "_err"}, err_of(w), err_exp);
        check_val({tag, "_ff"}, ff_of(w), first);
        check_val({tag, "_pass"}, pass_of(w), (nmis == 0) ? 1 : 0);
    endtask

    initial begin
        int w, sel;
        logic [7:0] tt;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rst_stim", stim_a, 0);
        check_val("rst_busy", busy_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_pass", pass_a, 0);
        check_val("rst_err", err_a, 0);
        check_val("rst_ff", ff_a, 0);
        check_val("rst_b_c", {busy_b, done_b, busy_c, done_c}, 0);

        run_sweep(0, 0, 8'b0000_0101, -1, "not");
        run_sweep(0, 1, 8'b0000_1110, -1, "and_vs_or");
        run_sweep(1, 3, 8'b0110_1001, -1, "xor_sat");
        run_sweep(1, 3, 8'b1001_0110, -1, "xor_reg");
        run_sweep(2, 2, 8'b0000_1110, -1, "or_settle1");

        // Abort at the fifth edge of a sweep; stim 0 already failed once.
        @(negedge clk);
        set_cfg(0, 2'd1, 8'b0000_1001);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        abort_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_a = 1'b0;
        check_val("abort_stim", stim_a, 0);
        check_val("abort_flags", {busy_a, done_a, pass_a}, 0);
        check_val("abort_err_hold", err_a, 1);
        repeat (3) @(negedge clk);
        check_val("abort_stays_idle", busy_a, 0);
        run_sweep(0, 1, 8'b0000_1000, -1, "post_abort");

        // Reset mid-sweep, then a start pulse while busy must be ignored.
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_out", {stim_a, busy_a, done_a, pass_a, err_a, ff_a}, 0);
        run_sweep(0, 1, 8'b0000_1000, 4, "busy_start");

        for (int i = 0; i < 24; i++) begin
            w   = $urandom_range(0, 2);
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                tt = 8'd0;
                for (int v = 0; v < (1 << in_w_of(w)); v++) tt[v] = ref_fn(sel, v, in_w_of(w));
            end else begin
                tt = 8'($urandom);
            end
            run_sweep(w, sel, tt, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
